i2c_subordinate_top: RTL and testbench

- Board-level I2C subordinate (slave) with a 128 x 8 register memory.
- The external controller addresses it at 7-bit device address 0x66 (bits on the wire: 1100110).
- The controller writes a memory pointer, then writes data bytes or reads them back, with automatic pointer increment.
- It uses the board pins directly: GPIO_0[0] is SDA, GPIO_0[1] is SCL, KEY[0] is reset, and LEDR shows status.

---
 rtl/i2c_subordinate_top.sv | 152 +++++++++++++++
 tb/tb_i2c_subordinate_top.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_subordinate_top.sv
// i2c_subordinate_top: I2C subordinate at DEV_ADDR exposing a MEM_DEPTH-byte register memory on board pins
module i2c_subordinate_top #(
  parameter logic [6:0] DEV_ADDR = 7'h66,
  parameter int MEM_DEPTH = 128
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  inout  wire  [35:0] GPIO_0,
  output logic [9:0]  LEDR
);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_MEM_ADDR, S_MEM_ACK, S_WAIT_RS,
    S_WRITE_DATA, S_WRITE_ACK, S_READ_DATA, S_READ_ACK, S_IGNORE
  } state_t;
  localparam logic [6:0] PTR_LAST = 7'(MEM_DEPTH - 1);
  logic clk, rst_n;
  state_t state, state_n;
  logic [1:0] scl_q, sda_q;
  logic scl, sda, scl_p, sda_p, rise, fall, start, stop;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, tx, tx_n, last, last_n, rd;
  logic [6:0] ptr, ptr_n, ptr_inc;
  logic ptr_last, end_f, end_n, flag, flag_n, nack, nack_n, sda_low, sda_low_n, we;
  logic [7:0] mem [MEM_DEPTH];
  logic unused;
  assign clk = CLOCK_50;
  assign rst_n = KEY[0];
  assign unused = ^{KEY[3:1], GPIO_0[35:2]};
  assign GPIO_0 = {35'bz, sda_low ? 1'b0 : 1'bz};
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign rise = scl & ~scl_p;
  assign fall = ~scl & scl_p;
  assign start = scl & scl_p & sda_p & ~sda;
  assign stop = scl & scl_p & ~sda_p & sda;
  assign ptr_last = ptr == PTR_LAST;
  assign ptr_inc = ptr_last ? ptr : ptr + 7'd1;
  assign rd = end_f ? 8'hFF : mem[ptr];
  assign LEDR = {nack, state != S_IDLE && state != S_IGNORE, last};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      tx <= '0;
      last <= '0;
      ptr <= '0;
      end_f <= 1'b0;
      flag <= 1'b0;
      nack <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      scl_q <= {scl_q[0], GPIO_0[1]};
      sda_q <= {sda_q[0], GPIO_0[0]};
      scl_p <= scl;
      sda_p <= sda;
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      tx <= tx_n;
      last <= last_n;
      ptr <= ptr_n;
      end_f <= end_n;
      flag <= flag_n;
      nack <= nack_n;
      sda_low <= sda_low_n;
    end
  always_ff @(posedge clk)
    if (we) mem[ptr] <= sh;
  // flag holds R/W in DEV_ACK, the mode bit in MEM_ACK and the controller's ACK in READ_ACK
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    tx_n = tx;
    last_n = last;
    ptr_n = ptr;
    end_n = end_f;
    flag_n = flag;
    nack_n = nack;
    sda_low_n = sda_low;
    we = 1'b0;
    case (state)
      S_DEV_ADDR, S_MEM_ADDR, S_WRITE_DATA:
        if (rise && cnt < 4'd8) begin
          sh_n = {sh[6:0], sda};
          cnt_n = cnt + 4'd1;
        end else if (fall && cnt == 4'd8) begin
          cnt_n = '0;
          if (state == S_DEV_ADDR) begin
            state_n = sh[7:1] == DEV_ADDR ? S_DEV_ACK : S_IGNORE;
            sda_low_n = sh[7:1] == DEV_ADDR;
            flag_n = sh[0];
          end else if (state == S_MEM_ADDR) begin
            state_n = S_MEM_ACK;
            ptr_n = sh[7:1];
            end_n = 1'b0;
            flag_n = sh[0];
            sda_low_n = 1'b1;
          end else begin
            state_n = S_WRITE_ACK;
            sda_low_n = ~end_f;
            nack_n = nack | end_f;
            we = ~end_f;
            last_n = end_f ? last : sh;
            end_n = end_f | ptr_last;
            ptr_n = end_f ? ptr : ptr_inc;
          end
        end
      S_DEV_ACK, S_MEM_ACK, S_WRITE_ACK:
        if (fall) begin
          sda_low_n = 1'b0;
          state_n = state == S_WRITE_ACK ? S_WRITE_DATA :
                    state == S_MEM_ACK ? (flag ? S_WAIT_RS : S_WRITE_DATA) :
                    flag ? S_READ_DATA : S_MEM_ADDR;
        end
      S_READ_DATA:
        if (fall && cnt == 4'd8) begin
          state_n = S_READ_ACK;
          sda_low_n = 1'b0;
          end_n = end_f | ptr_last;
          ptr_n = ptr_inc;
        end else if (fall) begin
          sda_low_n = ~tx[7];
          tx_n = {tx[6:0], 1'b0};
          cnt_n = cnt + 4'd1;
        end
      S_READ_ACK:
        if (rise) flag_n = ~sda;
        else if (fall) state_n = flag ? S_READ_DATA : S_IGNORE;
      default: ;
    endcase
    if (fall && state_n == S_READ_DATA && state != S_READ_DATA) begin
      tx_n = {rd[6:0], 1'b0};
      sda_low_n = ~rd[7];
      cnt_n = 4'd1;
    end
    if (start) begin
      state_n = S_DEV_ADDR;
      cnt_n = '0;
      sda_low_n = 1'b0;
      nack_n = 1'b0;
    end else if (stop) begin
      state_n = S_IDLE;
      sda_low_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_i2c_subordinate_top.sv
// tb_i2c_subordinate_top: bit-banged I2C controller with a transaction-level memory model
module tb_i2c_subordinate_top;
  localparam logic [7:0] DEV_W = 8'hCC, DEV_R = 8'hCD;
  logic clk = 1'b0;
  logic [3:0] key = 4'hF;
  logic scl = 1'b1, sda_ctl = 1'b1;
  wire [35:0] gpio;
  logic [9:0] ledr;
  assign gpio[0] = sda_ctl ? 1'bz : 1'b0;
  assign gpio[1] = scl;
  pullup (gpio);
  always #5 clk = ~clk;
  i2c_subordinate_top dut (.CLOCK_50(clk), .KEY(key), .GPIO_0(gpio), .LEDR(ledr));
  logic [7:0] m_mem [128];
  int m_ptr = 0;
  bit m_end = 1'b0, m_nack = 1'b0, m_addr = 1'b0;
  logic [7:0] m_last = 8'h00;
  bit chk_en = 1'b0, led_en = 1'b0, exp_sda = 1'b1;
  logic [9:0] exp_led = '0;
  string phase = "none";
  int checks = 0, errors = 0;
  always @(negedge clk) begin
    if (chk_en && sda_ctl) begin
      checks++;
      if (gpio[0] !== exp_sda) begin
        errors++;
        $display("FAIL sda %s: got %b want %b at %0t", phase, gpio[0], exp_sda, $time);
      end
    end
    if (led_en) begin
      checks++;
      if (ledr !== exp_led) begin
        errors++;
        $display("FAIL ledr %s: got %h want %h at %0t", phase, ledr, exp_led, $time);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic led_hold(input logic [9:0] v, input string nm);
    phase = nm;
    exp_led = v;
    exp_sda = 1'b1;
    chk_en = 1'b1;
    led_en = 1'b1;
    tick(6);
    chk_en = 1'b0;
    led_en = 1'b0;
  endtask
  task automatic model_reset();
    m_ptr = 0;
    m_end = 1'b0;
    m_nack = 1'b0;
    m_addr = 1'b0;
    m_last = 8'h00;
  endtask
  task automatic clk_bit(input bit v, input bit c, input bit e, input bit l);
    tick(5);
    sda_ctl = v;
    tick(5);
    scl = 1'b1;
    exp_sda = e;
    chk_en = c;
    led_en = l;
    tick(10);
    chk_en = 1'b0;
    led_en = 1'b0;
    scl = 1'b0;
  endtask
  task automatic start_c();
    if (!scl) begin
      tick(5);
      sda_ctl = 1'b1;
      tick(5);
      scl = 1'b1;
    end
    tick(5);
    sda_ctl = 1'b0;
    tick(5);
    scl = 1'b0;
    m_nack = 1'b0;
    m_addr = 1'b1;
  endtask
  task automatic stop_c();
    tick(5);
    sda_ctl = 1'b0;
    tick(5);
    scl = 1'b1;
    tick(5);
    sda_ctl = 1'b1;
    tick(5);
    m_addr = 1'b0;
    led_hold({m_nack, 1'b0, m_last}, "after stop");
  endtask
  task automatic send_byte(input logic [7:0] b, input bit ack);
    phase = "write bit";
    for (int i = 7; i >= 0; i--) clk_bit(b[i], b[i], 1'b1, 1'b0);
    phase = ack ? "expect ack" : "expect nack";
    exp_led = {m_nack, m_addr, m_last};
    clk_bit(1'b1, 1'b1, !ack, 1'b1);
  endtask
  task automatic recv_byte(input logic [7:0] e, input bit ack);
    phase = "read bit";
    exp_led = {m_nack, 1'b1, m_last};
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b1, e[i], 1'b1);
    phase = "controller ack";
    clk_bit(!ack, 1'b1, 1'b1, 1'b1);
  endtask
  task automatic wrong_dev(input logic [7:0] b);
    m_addr = 1'b0;
    send_byte(b, 1'b0);
  endtask
  task automatic set_ptr(input logic [6:0] a, input bit mode);
    m_ptr = int'(a);
    m_end = 1'b0;
    send_byte({a, mode}, 1'b1);
  endtask
  task automatic wr_data(input logic [7:0] d);
    bit ok;
    ok = !m_end;
    if (ok) begin
      m_mem[m_ptr] = d;
      m_last = d;
      if (m_ptr == 127) m_end = 1'b1;
      else m_ptr++;
    end else m_nack = 1'b1;
    send_byte(d, ok);
  endtask
  task automatic rd_data(input bit ack, input bit use_lit, input logic [7:0] lit);
    logic [7:0] e;
    e = use_lit ? lit : (m_end ? 8'hFF : m_mem[m_ptr]);
    if (m_ptr == 127) m_end = 1'b1;
    else m_ptr++;
    recv_byte(e, ack);
    if (!ack) m_addr = 1'b0;
  endtask
  task automatic write_txn(input logic [6:0] a, input int n);
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(a, 1'b0);
    repeat (n) wr_data(8'($urandom));
    stop_c();
  endtask
  task automatic read_txn(input logic [6:0] a, input int n);
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(a, 1'b1);
    start_c();
    send_byte(DEV_R, 1'b1);
    for (int i = 0; i < n; i++) rd_data(i < n - 1, 1'b0, 8'h00);
    stop_c();
  endtask
  task automatic reset_mid(input bit at_ack);
    logic [7:0] b;
    logic [6:0] a;
    int k;
    a = 7'($urandom);
    b = 8'($urandom);
    start_c();
    send_byte(DEV_W, 1'b1);
    if (at_ack) begin
      phase = "write bit";
      for (int i = 7; i >= 0; i--) clk_bit(a[i], a[i], 1'b1, 1'b0);
      tick(5);
      sda_ctl = 1'b1;
      tick(5);
      scl = 1'b1;
      phase = "ack before reset";
      exp_sda = 1'b0;
      chk_en = 1'b1;
      tick(3);
      key[0] = 1'b0;
      model_reset();
      phase = "reset during ack";
      exp_sda = 1'b1;
      exp_led = 10'h000;
      led_en = 1'b1;
      tick(4);
    end else begin
      set_ptr(a, 1'b0);
      k = $urandom_range(1, 7);
      phase = "partial byte";
      for (int i = 7; i >= 8 - k; i--) clk_bit(b[i], b[i], 1'b1, 1'b0);
      tick(3);
      key[0] = 1'b0;
      model_reset();
      sda_ctl = 1'b1;
      phase = "reset mid byte";
      exp_sda = 1'b1;
      exp_led = 10'h000;
      chk_en = 1'b1;
      led_en = 1'b1;
      tick(3);
      scl = 1'b1;
      tick(3);
    end
    key[0] = 1'b1;
    tick(4);
    chk_en = 1'b0;
    led_en = 1'b0;
    led_hold(10'h000, "after mid reset");
    start_c();
    send_byte(DEV_R, 1'b1);
    rd_data(1'b0, 1'b0, 8'h00);
    stop_c();
    if (!at_ack) read_txn(a, 1);
  endtask
  initial begin
    logic [7:0] b;
    tick(1);
    key[0] = 1'b0;
    tick(2);
    led_hold(10'h000, "in reset");
    key[0] = 1'b1;
    led_hold(10'h000, "idle after reset");
    write_txn(7'h00, 128);
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(7'h7E, 1'b0);
    wr_data(8'h01);
    wr_data(8'h02);
    wr_data(8'h06);
    stop_c();
    led_hold(10'h202, "end of memory");
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(7'h7C, 1'b0);
    wr_data(8'h01);
    wr_data(8'h02);
    stop_c();
    led_hold(10'h002, "recovery");
    start_c();
    wrong_dev(8'h4D);
    send_byte(8'hF8, 1'b0);
    send_byte(8'h77, 1'b0);
    stop_c();
    led_hold(10'h002, "wrong address");
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(7'h7C, 1'b1);
    start_c();
    send_byte(DEV_R, 1'b1);
    rd_data(1'b1, 1'b1, 8'h01);
    rd_data(1'b0, 1'b1, 8'h02);
    stop_c();
    start_c();
    send_byte(DEV_W, 1'b1);
    set_ptr(7'h7E, 1'b1);
    start_c();
    send_byte(DEV_R, 1'b1);
    rd_data(1'b1, 1'b1, 8'h01);
    rd_data(1'b1, 1'b1, 8'h02);
    rd_data(1'b0, 1'b1, 8'hFF);
    stop_c();
    reset_mid(1'b0);
    reset_mid(1'b1);
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0: write_txn($urandom_range(0, 1) ? 7'($urandom_range(122, 127)) : 7'($urandom), $urandom_range(1, 5));
        1: read_txn($urandom_range(0, 1) ? 7'($urandom_range(122, 127)) : 7'($urandom), $urandom_range(1, 5));
        2: begin
          do b = 8'($urandom); while (b[7:1] == 7'h66);
          start_c();
          wrong_dev(b);
          send_byte(8'($urandom), 1'b0);
          stop_c();
        end
        default: reset_mid($urandom_range(0, 1) == 1);
      endcase
    end
    read_txn(7'h70, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
